// File: rtl/load_store_unit_if.sv
// Request/response and memory-side bundle of the load/store unit.
// The slave view belongs to the unit itself. The master view belongs to whatever
// drives it: the execute stage on the request side and the memory on the bus side.
interface load_store_unit_if;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, is_store, funct3, addr_in, wdata_in, mem_ready, mem_rdata,
        output busy, done, fault, rdata_out, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output start, is_store, funct3, addr_in, wdata_in, mem_ready, mem_rdata,
        input  busy, done, fault, rdata_out, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. It takes one byte, halfword or word request
// from the execute stage and issues one aligned word access to memory. It places
// store data into the addressed lanes and extracts and extends the load lane.
// Misaligned requests and illegal width codes complete at once with a fault and
// never reach memory.
module load_store_unit (
    input  logic            clk,
    input  logic            reset,
    load_store_unit_if.slave lsu
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t      state, state_nxt;
    logic        is_store_p0;
    logic [2:0]  funct3_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [31:0] rdata_p1;

    // Legal width code for the direction, and natural alignment for that width.
    function automatic logic req_valid(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        logic aligned;
        if (st)
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        case (f3[1:0])
            2'b01:   aligned = ~a[0];
            2'b10:   aligned = (a == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

    // Byte enables of the addressed lanes.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store data across lanes so that the byte enables alone pick the target.
    function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Pick the addressed lane of the read word. Bit 2 of funct3 selects zero-extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [7:0]  bs;
        logic signed [15:0] hs;
        logic signed [31:0] ext;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h   = a[1] ? w[31:16] : w[15:0];
        bs  = signed'(b);
        hs  = signed'(h);
        ext = signed'(w);
        case (f3)
            3'b000:  ext = 32'(bs);
            3'b001:  ext = 32'(hs);
            3'b100:  ext = signed'({24'h0, b});
            3'b101:  ext = signed'({16'h0, h});
            default: ext = signed'(w);
        endcase
        return unsigned'(ext);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and handshake outputs. The bus is driven only while in ACCESS.
    always_comb begin
        state_nxt   = state;
        lsu.busy    = 1'b1;
        lsu.done    = 1'b0;
        lsu.fault   = 1'b0;
        lsu.mem_req = 1'b0;
        lsu.mem_we  = 1'b0;
        lsu.mem_be  = 4'b0000;
        case (state)
            IDLE: begin
                lsu.busy = 1'b0;
                if (lsu.start)
                    state_nxt = req_valid(lsu.is_store, lsu.funct3, lsu.addr_in[1:0]) ? ACCESS : ERR;
            end
            ACCESS: begin
                lsu.mem_req = 1'b1;
                lsu.mem_we  = is_store_p0;
                lsu.mem_be  = lane_be(funct3_p0, addr_p0[1:0]);
                if (lsu.mem_ready)
                    state_nxt = RESP;
            end
            RESP: begin
                lsu.done  = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                lsu.done  = 1'b1;
                lsu.fault = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request once in IDLE. It stays fixed for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_p0 <= 1'b0;
            funct3_p0   <= 3'b000;
            addr_p0     <= 32'h0;
            wdata_p0    <= 32'h0;
        end else if (state == IDLE && lsu.start) begin
            is_store_p0 <= lsu.is_store;
            funct3_p0   <= lsu.funct3;
            addr_p0     <= lsu.addr_in;
            wdata_p0    <= lsu.wdata_in;
        end
    end

    // Load result: updated only by an accepted load. It holds across stores and faults.
    always_ff @(posedge clk) begin
        if (reset)
            rdata_p1 <= 32'h0;
        else if (state == ACCESS && lsu.mem_ready && !is_store_p0)
            rdata_p1 <= load_extract(funct3_p0, addr_p0[1:0], lsu.mem_rdata);
    end

    assign lsu.mem_addr  = {addr_p0[31:2], 2'b00};
    assign lsu.mem_wdata = store_replicate(funct3_p0, wdata_p0);
    assign lsu.rdata_out = rdata_p1;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Each request pushes its expected completion
// to a queue, and the completion is popped and compared when done appears.
module tb_load_store_unit;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   done_count;
    exp_t sb[$];

    load_store_unit_if lsu ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .lsu   (lsu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lsu.done)
            done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current negedge and follow it to completion.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] mrd, input int waits,
                          input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic efault, input logic [31:0] erd, input bit poke);
        exp_t e;
        exp_t got;
        int   cyc;
        int   w;
        int   dc0;
        bit   fin;
        e.fault = efault;
        e.rdata = erd;
        e.lat   = efault ? 1 : 2 + waits;
        sb.push_back(e);
        dc0          = done_count;
        lsu.start    = 1'b1;
        lsu.is_store = st;
        lsu.funct3   = f3;
        lsu.addr_in  = a;
        lsu.wdata_in = wd;
        @(negedge clk);
        lsu.start = poke;
        cyc = 1;
        w   = waits;
        fin = 1'b0;
        while (!fin && cyc < 50) begin
            check("mem_req_on_fault", 32'(lsu.mem_req & efault), 32'h0);
            if (lsu.mem_req) begin
                check("mem_addr", lsu.mem_addr, {a[31:2], 2'b00});
                check("mem_be", 32'(lsu.mem_be), 32'(ebe));
                check("mem_we", 32'(lsu.mem_we), 32'(st));
                if (st)
                    check("mem_wdata", lsu.mem_wdata, ewd);
                lsu.mem_rdata = mrd;
                lsu.mem_ready = (w == 0);
                if (w > 0)
                    w--;
            end else begin
                lsu.mem_ready = 1'b0;
            end
            if (lsu.done) begin
                fin = 1'b1;
                if (sb.size() == 0) begin
                    check("done_without_request", 32'h1, 32'h0);
                end else begin
                    got = sb.pop_front();
                    check("fault", 32'(lsu.fault), 32'(got.fault));
                    check("rdata_out", lsu.rdata_out, got.rdata);
                    check("latency", 32'(cyc), 32'(got.lat));
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) begin
            check("done_timeout", 32'h0, 32'h1);
            if (sb.size() != 0)
                void'(sb.pop_front());
        end
        @(negedge clk);
        lsu.start     = 1'b0;
        lsu.mem_ready = 1'b0;
        check("busy_after_done", 32'(lsu.busy), 32'h0);
        check("done_count", 32'(done_count - dc0), 32'h1);
    endtask

    initial begin
        int dc0;
        checks        = 0;
        errors        = 0;
        done_count    = 0;
        reset         = 1'b1;
        lsu.start     = 1'b0;
        lsu.is_store  = 1'b0;
        lsu.funct3    = 3'b000;
        lsu.addr_in   = 32'h0;
        lsu.wdata_in  = 32'h0;
        lsu.mem_ready = 1'b0;
        lsu.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(lsu.busy), 32'h0);
        check("rst_done", 32'(lsu.done), 32'h0);
        check("rst_fault", 32'(lsu.fault), 32'h0);
        check("rst_mem_req", 32'(lsu.mem_req), 32'h0);
        check("rst_rdata", lsu.rdata_out, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // LB from the top byte lane: negative value is sign-extended
        do_req(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80, 1'b0);
        // LHU from the upper half, three wait cycles
        do_req(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 4'b1100, 32'h0, 1'b0, 32'h0000_8001, 1'b0);
        // SB to lane 1: byte replicated, load result untouched
        do_req(1'b1, 3'b000, 32'h0000_3001, 32'hAABB_CCDD, 32'h0, 0, 4'b0010, 32'hDDDD_DDDD, 1'b0, 32'h0000_8001, 1'b0);
        // Misaligned SW and illegal load width code fault immediately
        do_req(1'b1, 3'b010, 32'h0000_4002, 32'h1111_2222, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 32'h0000_8001, 1'b0);
        do_req(1'b0, 3'b011, 32'h0000_5000, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 32'h0000_8001, 1'b0);
        // LW with one wait cycle
        do_req(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h1234_5678, 1, 4'b1111, 32'h0, 1'b0, 32'h1234_5678, 1'b0);
        // LH from the upper half, sign-extended
        do_req(1'b0, 3'b001, 32'h0000_6006, 32'h0, 32'h8000_7FFF, 0, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8000, 1'b0);
        // LBU from lane 2, zero-extended
        do_req(1'b0, 3'b100, 32'h0000_7002, 32'h0, 32'h00C3_0000, 0, 4'b0100, 32'h0, 1'b0, 32'h0000_00C3, 1'b0);
        // SH to the upper half: halfword replicated
        do_req(1'b1, 3'b001, 32'h0000_8002, 32'h1234_ABCD, 32'h0, 2, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0000_00C3, 1'b0);
        // More faults: misaligned LW, misaligned LH, illegal store width code
        do_req(1'b0, 3'b010, 32'h0000_9002, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 32'h0000_00C3, 1'b0);
        do_req(1'b0, 3'b001, 32'h0000_9001, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 32'h0000_00C3, 1'b0);
        do_req(1'b1, 3'b100, 32'h0000_A000, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1'b1, 32'h0000_00C3, 1'b0);
        // start held while busy and in the done cycle: ignored, exactly one done
        do_req(1'b0, 3'b000, 32'h0000_A000, 32'h0, 32'h0000_007F, 2, 4'b0001, 32'h0, 1'b0, 32'h0000_007F, 1'b1);
        do_req(1'b1, 3'b010, 32'h0000_B000, 32'hCAFE_F00D, 32'h0, 1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0000_007F, 1'b1);

        // Reset in ACCESS with memory stalled: request aborted, no done
        lsu.start    = 1'b1;
        lsu.is_store = 1'b0;
        lsu.funct3   = 3'b010;
        lsu.addr_in  = 32'h0000_C000;
        @(negedge clk);
        lsu.start     = 1'b0;
        lsu.mem_ready = 1'b0;
        check("abort_in_access", 32'(lsu.mem_req), 32'h1);
        dc0   = done_count;
        reset = 1'b1;
        @(negedge clk);
        check("abort_mem_req", 32'(lsu.mem_req), 32'h0);
        check("abort_busy", 32'(lsu.busy), 32'h0);
        check("abort_rdata", lsu.rdata_out, 32'h0);
        check("abort_done", 32'(lsu.done), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_count - dc0), 32'h0);
        check("abort_idle", 32'(lsu.busy), 32'h0);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
